// File: rtl/rx_ring_buffer.sv
// rx_ring_buffer: per-channel sample rings sharing one simple-dual-port RAM,
// with fill/overrun accounting and fixed-size block readout.
module rx_ring_buffer #(
  parameter int DATA_W     = 16,
  parameter int CHANS      = 4,
  parameter int DEPTH_LOG2 = 10,
  parameter int BLK_LOG2   = 8,
  localparam int CH_W      = (CHANS > 1) ? $clog2(CHANS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [CH_W-1:0]       wr_chan,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_start,
  input  logic [CH_W-1:0]       rd_chan,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  rd_busy,
  output logic                  rd_err,
  output logic [CHANS-1:0]      blk_avail,
  output logic [CHANS-1:0]      ovfl,
  input  logic [CHANS-1:0]      ovfl_clr,
  output logic [DEPTH_LOG2:0]   fill_lvl
);
  localparam int AW = $clog2(CHANS) + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] BLK_FILL = (DEPTH_LOG2+1)'(1 << BLK_LOG2);
  localparam logic [BLK_LOG2:0]   LAST_CNT = (BLK_LOG2+1)'((1 << BLK_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [BLK_LOG2:0]     cnt_q, cnt_d;
  logic                  dcnt_q, dcnt_d;
  logic [DEPTH_LOG2-1:0] wptr_q [CHANS];
  logic [DEPTH_LOG2-1:0] wptr_d [CHANS];
  logic [DEPTH_LOG2-1:0] rptr_q [CHANS];
  logic [DEPTH_LOG2-1:0] rptr_d [CHANS];
  logic [DEPTH_LOG2:0]   fill_q [CHANS];
  logic [DEPTH_LOG2:0]   fill_d [CHANS];
  logic [CHANS-1:0]      blk_avail_q, blk_avail_d, ovfl_q, ovfl_d;
  logic [CHANS-1:0]      wsel, rsel, drop;
  logic                  wr_ok, issue, issue_q, last_q;
  logic                  rd_valid_q, rd_last_q, rd_err_q, rd_err_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d, ram_q;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [DATA_W-1:0]     mem [0:(1<<AW)-1];

  assign issue    = state_q == READ;
  assign wr_ok    = wr_valid && fill_q[wr_chan] != FULL;
  assign wr_addr  = AW'({wr_chan, wptr_q[wr_chan]});
  assign rd_addr  = AW'({ch_q, rptr_q[ch_q]});
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_err   = rd_err_q;
  assign rd_busy  = state_q != IDLE;
  assign blk_avail = blk_avail_q;
  assign ovfl     = ovfl_q;
  assign fill_lvl = fill_q[rd_chan];
  assign rd_data_d = issue_q ? ram_q : rd_data_q;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    rd_err_d = 1'b0;
    if (state_q == IDLE && rd_start) begin
      rd_err_d = !blk_avail_q[rd_chan];
      state_d  = blk_avail_q[rd_chan] ? READ : IDLE;
      ch_d     = rd_chan;
      cnt_d    = '0;
    end else if (state_q == READ) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == LAST_CNT) ? DRAIN : READ;
      dcnt_d  = 1'b0;
    end else if (state_q == DRAIN) begin
      dcnt_d  = 1'b1;
      state_d = dcnt_q ? IDLE : DRAIN;
    end
  end

  // A same-cycle write and read issue on one channel net to zero fill change.
  always_comb begin
    wsel = '0;
    rsel = '0;
    drop = '0;
    for (int n = 0; n < CHANS; n++) begin
      wsel[n]        = wr_ok && wr_chan == CH_W'(n);
      rsel[n]        = issue && ch_q == CH_W'(n);
      drop[n]        = wr_valid && !wr_ok && wr_chan == CH_W'(n);
      wptr_d[n]      = wptr_q[n] + DEPTH_LOG2'(wsel[n]);
      rptr_d[n]      = rptr_q[n] + DEPTH_LOG2'(rsel[n]);
      fill_d[n]      = fill_q[n] + (DEPTH_LOG2+1)'(wsel[n]) - (DEPTH_LOG2+1)'(rsel[n]);
      blk_avail_d[n] = fill_d[n] >= BLK_FILL;
      ovfl_d[n]      = (ovfl_q[n] & ~ovfl_clr[n]) | drop[n];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (issue) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      dcnt_q      <= 1'b0;
      for (int n = 0; n < CHANS; n++) begin
        wptr_q[n] <= '0;
        rptr_q[n] <= '0;
        fill_q[n] <= '0;
      end
      blk_avail_q <= '0;
      ovfl_q      <= '0;
      issue_q     <= 1'b0;
      last_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fill_q      <= fill_d;
      blk_avail_q <= blk_avail_d;
      ovfl_q      <= ovfl_d;
      issue_q     <= issue;
      last_q      <= issue && cnt_q == LAST_CNT;
      rd_valid_q  <= issue_q;
      rd_last_q   <= last_q;
      rd_err_q    <= rd_err_d;
      rd_data_q   <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_rx_ring_buffer.sv
// tb_rx_ring_buffer: directed scoreboard bench for rx_ring_buffer.
module tb_rx_ring_buffer;
  localparam int DATA_W = 16, CHANS = 4, DEPTH_LOG2 = 10, BLK_LOG2 = 8;
  localparam int DEPTH = 1 << DEPTH_LOG2, BLK = 1 << BLK_LOG2, CH_W = 2;

  logic              clk = 1'b0, rst = 1'b1;
  logic              wr_valid = 1'b0, rd_start = 1'b0;
  logic [CH_W-1:0]   wr_chan = '0, rd_chan = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [CHANS-1:0]  ovfl_clr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last, rd_busy, rd_err;
  logic [CHANS-1:0]  blk_avail, ovfl;
  logic [DEPTH_LOG2:0] fill_lvl;

  rx_ring_buffer #(.DATA_W(DATA_W), .CHANS(CHANS), .DEPTH_LOG2(DEPTH_LOG2), .BLK_LOG2(BLK_LOG2)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_chan(wr_chan), .wr_data(wr_data),
    .rd_start(rd_start), .rd_chan(rd_chan), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_busy(rd_busy), .rd_err(rd_err), .blk_avail(blk_avail),
    .ovfl(ovfl), .ovfl_clr(ovfl_clr), .fill_lvl(fill_lvl)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int mq [CHANS][$];
  int exp_q [$];
  bit mov [CHANS];
  bit start_ok;
  int blk_cnt = 0, seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    compared++;
    assert (got === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [CHANS-1:0] ovfl_vec();
    for (int n = 0; n < CHANS; n++) ovfl_vec[n] = mov[n];
  endfunction

  function automatic logic [CHANS-1:0] avail_vec();
    for (int n = 0; n < CHANS; n++) avail_vec[n] = mq[n].size() >= BLK;
  endfunction

  always @(negedge clk) begin
    if (rst) blk_cnt = 0;
    else if (rd_valid) begin
      if (exp_q.size() == 0) check("word_expected", 32'(exp_q.size()), 1);
      else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      check("rd_last", 32'(rd_last), 32'(blk_cnt == BLK - 1));
      blk_cnt = (blk_cnt + 1) % BLK;
      seen++;
    end else if (rd_last) check("rd_last_idle", 32'(rd_last), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1;
    wr_chan  = CH_W'(ch);
    wr_data  = DATA_W'(d);
    if (mq[ch].size() < DEPTH) mq[ch].push_back(d);
    else mov[ch] = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_begin(input int ch);
    rd_start = 1'b1;
    rd_chan  = CH_W'(ch);
    start_ok = mq[ch].size() >= BLK;
    if (start_ok) repeat (BLK) exp_q.push_back(mq[ch].pop_front());
  endtask

  task automatic check_start();
    check("rd_err_start", 32'(rd_err), 32'(!start_ok));
    check("rd_busy_start", 32'(rd_busy), 32'(start_ok));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && rd_busy; i++) tick();
    check("busy_timeout", 32'(rd_busy), 0);
    check("block_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic read_block(input int ch);
    rd_begin(ch);
    tick();
    rd_start = 1'b0;
    check_start();
    wait_idle();
  endtask

  task automatic check_model();
    for (int n = 0; n < CHANS; n++) begin
      rd_chan = CH_W'(n);
      #1;
      check("fill_lvl", 32'(fill_lvl), 32'(mq[n].size()));
    end
    check("blk_avail", 32'(blk_avail), 32'(avail_vec()));
    check("ovfl", 32'(ovfl), 32'(ovfl_vec()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    tick();
    tick();
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_busy", 32'(rd_busy), 0);
    check("rst_rd_err", 32'(rd_err), 0);
    check_model();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) wr(2, i);
    check_model();
    rd_begin(2);
    tick();
    rd_start = 1'b0;
    check_start();
    check("latency_c1", 32'(rd_valid), 0);
    tick();
    check("latency_c2", 32'(rd_valid), 0);
    tick();
    check("latency_c3", 32'(rd_valid), 1);
    wait_idle();
    check_model();

    for (int i = 0; i < 255; i++) wr(1, 'h1000 + i);
    rd_begin(1);
    tick();
    rd_start = 1'b0;
    check("rd_err_pulse", 32'(rd_err), 1);
    check("rd_busy_reject", 32'(rd_busy), 0);
    tick();
    check("rd_err_single", 32'(rd_err), 0);
    check_model();

    for (int i = 0; i < 1030; i++) wr(0, i);
    check_model();
    ovfl_clr = 4'b0001;
    wr(0, 1030);
    ovfl_clr = '0;
    check("ovfl_set_wins", 32'(ovfl), 32'(4'b0001));
    ovfl_clr = 4'b0001;
    mov[0] = 1'b0;
    tick();
    ovfl_clr = '0;
    check("ovfl_cleared", 32'(ovfl), 0);
    repeat (4) read_block(0);
    check_model();

    for (int i = 0; i < 900; i++) wr(3, 'h3000 + i);
    repeat (3) read_block(3);
    for (int i = 900; i < 1068; i++) wr(3, 'h3000 + i);
    check_model();
    rd_begin(3);
    for (int i = 0; i < 260; i++) begin
      wr(3, 'h3000 + 1068 + i);
      rd_start = 1'b0;
      if (i == 0) check_start();
    end
    wait_idle();
    rd_chan = 2'd3;
    #1;
    check("fill_ch3_mixed", 32'(fill_lvl), 304);
    read_block(3);
    check_model();

    wr(1, 'h1000 + 255);
    rd_begin(1);
    for (int i = 0; i < 520; i++) begin
      if (i % 2 == 0) wr(0, 'h5000 + i / 2);
      else wr(1, 'h6000 + i / 2);
      rd_start = 1'b0;
      if (i == 0) check_start();
    end
    wait_idle();
    check_model();
    read_block(0);
    read_block(1);
    check_model();

    for (int i = 0; i < 300; i++) wr(1, 'h7000 + i);
    rd_begin(1);
    tick();
    rd_start = 1'b0;
    check_start();
    s0 = seen;
    for (int i = 0; i < 400 && seen < s0 + 100; i++) tick();
    check("valid_before_rst", 32'(rd_valid), 1);
    rst = 1'b1;
    #1;
    check("valid_in_rst", 32'(rd_valid), 0);
    exp_q.delete();
    for (int n = 0; n < CHANS; n++) begin
      mq[n].delete();
      mov[n] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("busy_after_rst", 32'(rd_busy), 0);
    check_model();
    read_block(1);
    tick();
    check("rd_err_after_rst", 32'(rd_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
